deserializer: RTL and testbench
===============================

DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 SHALL have parameter: MAX_BITS, default 136, maximum frame length and width of out.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: enable  input  1  high = capture one bit per clock; low = hold all state.
REQ-005 SHALL have port: in  input  1  serial data bit, sampled on rising clk while capturing.
REQ-006 SHALL have port: framesize  input  8  number of bits in the frame (1..MAX_BITS).
REQ-007 SHALL have port: out  output  MAX_BITS  deserialized frame, registered.
REQ-008 SHALL have port: complete  output  1  high once framesize bits are captured, registered.

Function
REQ-009 SHALL keep an 8-bit bit counter (cnt) counting captured bits, 0..framesize.
REQ-010 SHALL capture when enable=1 and complete=0 on a rising clk: out <= {out[MAX_BITS-2:0], in}; cnt <= cnt+1.
REQ-011 SHALL order bits MSB-first, right-aligned: after N captures the first bit is at out[N-1] and the last at out[0]; out[MAX_BITS-1:N] stay 0.
REQ-012 SHALL assert complete on the same edge that captures bit number framesize (cnt+1 == framesize), with out already holding the full frame.
REQ-013 SHALL latch complete high and stop capturing until reset; out and cnt hold while complete=1 regardless of enable or in.
REQ-014 SHALL hold out, cnt and complete unchanged on any edge where enable=0; deasserting enable mid-frame pauses capture and reasserting resumes it without loss.
REQ-015 SHALL sample framesize every cycle; if framesize is lowered to a value <= cnt mid-frame, complete asserts on the next enabled edge without capturing.
REQ-016 SHALL treat framesize = 0 as a completed frame: complete asserts on the first enabled edge, no bit captured, out stays 0.
REQ-017 SHALL clamp framesize > MAX_BITS to MAX_BITS.
REQ-018 SHALL have no combinational path from inputs to out or complete.

Reset
REQ-019 SHALL, while reset=0, asynchronously force out=0, cnt=0, complete=0.
REQ-020 SHALL discard any partial frame when reset is asserted mid-capture; capture restarts from cnt=0 on the first enabled edge after release.
REQ-021 SHALL treat in, enable and framesize as don't-care during reset.

Structure
REQ-022 SHALL place MAX_BITS default (136) and counter width (8) in the shared cmd package with the other command-path constants.
REQ-023 SHALL be a single module with no sub-modules; counter and shift register are local registers.

Verification
REQ-024 SHALL verify basic frame: framesize=12, enable=1, bits 1,0,1,1,0,0,1,0,1,0,0,1 -> complete rises on 12th edge, out[11:0]=12'b101100101001, out[135:12]=0.
REQ-025 SHALL verify pause: framesize=8, enable dropped for 3 cycles after 4 bits of 8'b11001010 -> out and cnt frozen during pause; after resume complete on 8th capture, out[7:0]=8'hCA.
REQ-026 SHALL verify sticky completion: after complete with framesize=4, out[3:0]=4'b1001, toggle in for 10 cycles with enable=1 -> out and complete unchanged.
REQ-027 SHALL verify reset mid-frame: assert reset after 5 of 12 bits -> out=0, complete=0 immediately; new 12-bit frame then completes after exactly 12 enabled edges.
REQ-028 SHALL verify maximum length: framesize=136, alternating pattern starting with 1 -> complete on 136th edge, out[135]=1, out[0]=0.
REQ-029 SHALL verify boundaries: framesize=0 -> complete on first enabled edge with out=0; framesize=200 -> behaves as 136.

Source files
------------

// File: rtl/deserializer_pkg.sv
// Shared command-path constants for the serial frame capture logic.
// The counter is sized so it can hold any frame length up to MAX_BITS.
package deserializer_pkg;

  localparam int DESER_MAX_BITS = 136;
  localparam int DESER_CNT_W    = 8;

  // Limits a requested frame length to the widest frame the register can hold.
  function automatic logic [DESER_CNT_W-1:0] clamp_framesize(
    input logic [DESER_CNT_W-1:0] fs,
    input logic [DESER_CNT_W-1:0] max_fs
  );
    return (fs > max_fs) ? max_fs : fs;
  endfunction

endpackage

// File: rtl/deserializer.sv
// Serial-to-parallel frame capture: shifts bits in MSB-first and raises a
// sticky complete flag once the requested number of bits has arrived.
module deserializer
  import deserializer_pkg::*;
#(
  parameter int MAX_BITS = DESER_MAX_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   in,
  input  logic [7:0]             framesize,
  output logic [MAX_BITS-1:0]    out,
  output logic                   complete
);

  localparam logic [DESER_CNT_W-1:0] MAX_FS = DESER_CNT_W'(MAX_BITS);

  logic [MAX_BITS-1:0]    out_q, out_d;
  logic [DESER_CNT_W-1:0] cnt_q, cnt_d;
  logic                   complete_q, complete_d;
  logic [DESER_CNT_W-1:0] limit;

  assign limit = clamp_framesize(framesize, MAX_FS);

  // A count already at or past the limit (zero-length frame, or framesize
  // lowered mid-frame) completes without taking another bit.
  always_comb begin
    out_d      = out_q;
    cnt_d      = cnt_q;
    complete_d = complete_q;
    if (enable && !complete_q) begin
      if (cnt_q >= limit) begin
        complete_d = 1'b1;
      end else begin
        out_d = {out_q[MAX_BITS-2:0], in};
        cnt_d = cnt_q + 1'b1;
        if ((cnt_q + 1'b1) == limit) begin
          complete_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q      <= '0;
      cnt_q      <= '0;
      complete_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      cnt_q      <= cnt_d;
      complete_q <= complete_d;
    end
  end

  assign out      = out_q;
  assign complete = complete_q;

endmodule

// File: tb/tb_deserializer.sv
// Randomized self-checking bench for deserializer, compared every edge
// against a queue-based model of the captured bit stream.
module tb_deserializer;

  localparam int MB = 136;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          in;
  logic [7:0]    framesize;
  logic [MB-1:0] out;
  logic          complete;

  int checkCount = 0;
  int failCount  = 0;

  // Reference model: the bits captured so far, oldest first, and the done flag.
  logic mBits[$];
  logic mDone;

  deserializer #(.MAX_BITS(MB)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .in        (in),
    .framesize (framesize),
    .out       (out),
    .complete  (complete)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [MB-1:0] observed,
                             input logic [MB-1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Oldest bit lands at position n-1, newest at position 0.
  function automatic logic [MB-1:0] modelOut();
    logic [MB-1:0] r;
    int n;
    r = '0;
    n = mBits.size();
    for (int i = 0; i < n; i++) r[n-1-i] = mBits[i];
    return r;
  endfunction

  task automatic modelStep(input logic en, input logic b, input int fs);
    int lim;
    lim = (fs > MB) ? MB : fs;
    if (en && !mDone) begin
      if (mBits.size() >= lim) begin
        mDone = 1'b1;
      end else begin
        mBits.push_back(b);
        if (mBits.size() == lim) mDone = 1'b1;
      end
    end
  endtask

  task automatic applyStimulus(input logic en, input logic b, input int fs, input string tag);
    enable    = en;
    in        = b;
    framesize = fs[7:0];
    @(posedge clk);
    modelStep(en, b, fs);
    #1;
    checkOutput({tag, "_out"}, out, modelOut());
    checkOutput({tag, "_cmp"}, {{(MB-1){1'b0}}, complete}, {{(MB-1){1'b0}}, mDone});
  endtask

  task automatic applyReset(input string tag);
    enable = 1'b0;
    reset  = 1'b0;
    #1;
    mBits.delete();
    mDone = 1'b0;
    checkOutput({tag, "_rst_out"}, out, '0);
    checkOutput({tag, "_rst_cmp"}, {{(MB-1){1'b0}}, complete}, '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic sendBits(input logic [MB-1:0] vec, input int n, input int fs, input string tag);
    for (int i = n - 1; i >= 0; i--) applyStimulus(1'b1, vec[i], fs, tag);
  endtask

  initial begin
    logic [MB-1:0] v;
    int edges;
    int fs;

    reset     = 1'b0;
    enable    = 1'b0;
    in        = 1'b0;
    framesize = 8'd0;
    mDone     = 1'b0;
    #12;
    checkOutput("init_out", out, '0);
    checkOutput("init_cmp", {{(MB-1){1'b0}}, complete}, '0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Basic 12-bit frame
    v = '0;
    v[11:0] = 12'b101100101001;
    sendBits(v, 12, 12, "basic");
    checkOutput("basic_final", out, {{(MB-12){1'b0}}, 12'b101100101001});
    checkOutput("basic_done", {{(MB-1){1'b0}}, complete}, {{(MB-1){1'b0}}, 1'b1});

    // Pause after 4 bits of 8'hCA
    applyReset("pause");
    v = '0;
    v[7:0] = 8'hCA;
    for (int i = 7; i >= 4; i--) applyStimulus(1'b1, v[i], 8, "pause_a");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 8, "pause_hold");
    checkOutput("pause_frozen", out, {{(MB-4){1'b0}}, 4'b1100});
    for (int i = 3; i >= 0; i--) applyStimulus(1'b1, v[i], 8, "pause_b");
    checkOutput("pause_final", out, {{(MB-8){1'b0}}, 8'hCA});

    // Sticky completion
    applyReset("sticky");
    v = '0;
    v[3:0] = 4'b1001;
    sendBits(v, 4, 4, "sticky");
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'(i % 2), 4, "sticky_hold");
    checkOutput("sticky_final", out, {{(MB-4){1'b0}}, 4'b1001});

    // Reset mid-frame, then a fresh 12-bit frame
    applyReset("mid");
    v = '0;
    v[11:0] = 12'($urandom);
    for (int i = 11; i >= 7; i--) applyStimulus(1'b1, v[i], 12, "mid_part");
    applyReset("mid");
    edges = 0;
    while (!complete && edges < 20) begin
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 12, "mid_new");
      edges++;
    end
    checkOutput("mid_edges", MB'(edges), MB'(12));

    // Maximum length, alternating starting with 1
    applyReset("max");
    for (int i = 0; i < MB; i++) applyStimulus(1'b1, 1'(i % 2 == 0), MB, "max");
    checkOutput("max_msb", {{(MB-1){1'b0}}, out[MB-1]}, {{(MB-1){1'b0}}, 1'b1});
    checkOutput("max_lsb", {{(MB-1){1'b0}}, out[0]}, '0);

    // Zero-length frame
    applyReset("zero");
    applyStimulus(1'b1, 1'b1, 0, "zero");
    checkOutput("zero_done", {{(MB-1){1'b0}}, complete}, {{(MB-1){1'b0}}, 1'b1});
    checkOutput("zero_out", out, '0);

    // Oversized framesize clamps to MAX_BITS
    applyReset("big");
    for (int i = 0; i < MB; i++) applyStimulus(1'b1, 1'($urandom_range(0, 1)), 200, "big");
    checkOutput("big_done", {{(MB-1){1'b0}}, complete}, {{(MB-1){1'b0}}, 1'b1});
    applyStimulus(1'b1, 1'b1, 200, "big_hold");

    // Framesize lowered below the current count mid-frame
    applyReset("lower");
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'($urandom_range(0, 1)), 20, "lower_a");
    applyStimulus(1'b1, 1'b1, 5, "lower_b");

    // Random frames with random enable gaps
    for (int f = 0; f < 8; f++) begin
      applyReset("rnd");
      fs = (f == 0) ? 1 : $urandom_range(1, 150);
      edges = 0;
      while (!mDone && edges < 400) begin
        applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), fs, "rnd");
        edges++;
      end
      checkOutput("rnd_done", {{(MB-1){1'b0}}, complete}, {{(MB-1){1'b0}}, 1'b1});
      for (int i = 0; i < 3; i++)
        applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), fs, "rnd_hold");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
